// File: rtl/sync_fifo_ctrl.sv
// Pointer/flag controller for a single-clock FIFO wrapped around a 1-cycle-latency SRAM.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_ctrl #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  data_valid
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wr_q, rd_q;
  logic [PW-1:0] wr_nxt, rd_nxt;
  logic [PW-1:0] count_nxt;
  logic          full_nxt, empty_nxt;

  // Strobes are forced low during reset; full is already 0 there, so push alone would leak through.
  assign wr_en  = push & ~full  & ~reset;
  assign rd_en  = pop  & ~empty & ~reset;
  assign wr_ptr = wr_q[ADDR_WIDTH-1:0];
  assign rd_ptr = rd_q[ADDR_WIDTH-1:0];

  assign wr_nxt = wr_q + PW'(wr_en);
  assign rd_nxt = rd_q + PW'(rd_en);

  // Flags are registered from the post-transfer pointers so they are valid right after the edge.
  assign full_nxt  = (wr_nxt[ADDR_WIDTH] != rd_nxt[ADDR_WIDTH]) &&
                     (wr_nxt[ADDR_WIDTH-1:0] == rd_nxt[ADDR_WIDTH-1:0]);
  assign empty_nxt = (wr_nxt == rd_nxt);

  always_comb begin
    // NOTE: default first so every path assigns count_nxt and no latch is inferred.
    count_nxt = count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count + PW'(1);
      2'b01:   count_nxt = count - PW'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      data_valid <= 1'b0;
    end else begin
      wr_q       <= wr_nxt;
      rd_q       <= rd_nxt;
      count      <= count_nxt;
      full       <= full_nxt;
      empty      <= empty_nxt;
      data_valid <= rd_en;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow  | (push & full);
      underflow <= underflow | (pop  & empty);
    end
  end
`endif

endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, default 3, SRAM address width; FIFO depth SHALL be 2**ADDR_WIDTH (8 by default).
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: push  input  1  write request from upstream producer.
REQ-005 Port: pop  input  1  read request from downstream consumer.
REQ-006 Port: wr_en  output  1  write enable to SRAM write side.
REQ-007 Port: wr_ptr  output  ADDR_WIDTH  SRAM write address.
REQ-008 Port: rd_en  output  1  read enable to SRAM read side.
REQ-009 Port: rd_ptr  output  ADDR_WIDTH  SRAM read address.
REQ-010 Port: full  output  1  FIFO holds 2**ADDR_WIDTH entries.
REQ-011 Port: empty  output  1  FIFO holds 0 entries.
REQ-012 Port: count  output  ADDR_WIDTH+1  current occupancy, 0 to 2**ADDR_WIDTH.
REQ-013 Port: data_valid  output  1  SRAM data_out holds the word read by the previous accepted pop.
REQ-014 Ports (only with FIFO_ERR_FLAGS_EN): overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 wr_en SHALL be combinational push & ~full; rd_en SHALL be combinational pop & ~empty.
REQ-016 Internal write/read pointers SHALL be ADDR_WIDTH+1 bits; wr_ptr/rd_ptr SHALL be their low ADDR_WIDTH bits.
REQ-017 Accepted push (wr_en=1): write pointer SHALL increment by 1 at the edge, wrapping modulo 2**(ADDR_WIDTH+1).
REQ-018 Accepted pop (rd_en=1): read pointer SHALL increment by 1 at the edge with the same wrap rule.
REQ-019 full SHALL be 1 when pointer MSBs differ and low bits are equal; empty SHALL be 1 when the pointers are equal; both registered, valid from the edge after the causing transfer.
REQ-020 count SHALL be registered: +1 on push-only, -1 on pop-only, unchanged on both or neither.
REQ-021 Push while full SHALL be dropped: no pointer, count, or SRAM change.
REQ-022 Pop while empty SHALL be ignored: no pointer or count change; data_valid stays 0 next cycle.
REQ-023 Simultaneous push and pop when neither full nor empty SHALL both be accepted; count unchanged.
REQ-024 Push and pop when full: pop accepted, push dropped; full deasserts next cycle, count becomes max-1.
REQ-025 Push and pop when empty: push accepted, pop ignored (no fall-through); empty deasserts next cycle.
REQ-026 data_valid SHALL be a register of rd_en: asserted exactly one cycle after each accepted pop, matching the one-cycle SRAM read latency.
REQ-027 Read-during-write to the same address cannot occur because rd_en requires ~empty and wr_en requires ~full.

Reset
REQ-028 Asserting reset SHALL immediately clear both pointers, count=0, empty=1, full=0, data_valid=0, overflow=0, underflow=0, independent of clk.
REQ-029 While reset is high, wr_en and rd_en SHALL be 0.
REQ-030 Reset mid-operation SHALL discard all contents; the first push after release SHALL write address 0.

Configuration
REQ-031 Macro FIFO_ERR_FLAGS_EN defined: overflow SHALL set on the edge after any push while full and underflow on the edge after any pop while empty; both stay set until reset.
REQ-032 Macro FIFO_ERR_FLAGS_EN undefined: overflow/underflow ports and logic SHALL be absent; all other behaviour unchanged.

Verification
REQ-033 Reset, then 8 pushes (ADDR_WIDTH=3) -> wr_ptr 0..7, count 8, full=1, empty=0.
REQ-034 From full, 9th push -> wr_en=0, count stays 8; with FIFO_ERR_FLAGS_EN, overflow=1 next cycle and held.
REQ-035 From full, 8 pops -> rd_ptr 0..7, data_valid high one cycle after each pop, count 0, empty=1.
REQ-036 Pop while empty -> rd_en=0, data_valid=0; with FIFO_ERR_FLAGS_EN, underflow=1.
REQ-037 Count 4, push+pop for 12 cycles -> count stays 4, both pointers wrap 7->0, and full and empty stay 0.
REQ-038 Count 5, assert reset between edges -> count=0 and empty=1 immediately; next push uses wr_ptr=0.
